// File: rtl/switch_arbiter.sv
// Round-robin arbiter for a 4-port switch: registered pop grant in C+1, output valid/select in C+2.
// A port is eligible only when every target output is ready, so multicast never gets a partial set of its outputs.
module switch_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2,
  parameter int DROP_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [4*NUM_PORTS-1:0]     req_target,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [SEL_W*NUM_PORTS-1:0] out_sel,
  output logic [DROP_W-1:0]          drop_count
);

  logic [NUM_PORTS-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]           rr_q, rr_d;
  logic [NUM_PORTS-1:0]       pend_vld_q, pend_vld_d;
  logic [SEL_W*NUM_PORTS-1:0] pend_sel_q, pend_sel_d;
  logic [NUM_PORTS-1:0]       out_valid_q;
  logic [SEL_W*NUM_PORTS-1:0] out_sel_q, out_sel_d;
  logic [DROP_W-1:0]          drop_q, drop_d;

  logic [NUM_PORTS-1:0] claimed;
  logic [NUM_PORTS-1:0] mask;
  logic [SEL_W-1:0]     idx;
  logic                 found;
  logic [2:0]           drops;
  logic [DROP_W:0]      drop_sum;

  always_comb begin
    grant_d    = '0;
    pend_sel_d = pend_sel_q;
    rr_d       = rr_q;
    claimed    = '0;
    mask       = '0;
    idx        = '0;
    found      = 1'b0;
    drops      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx  = rr_q + SEL_W'(k);
      mask = req_target[int'(idx)*NUM_PORTS +: NUM_PORTS];
      // A port granted last cycle still shows its popped head; skip it.
      if (req_valid[idx] && !grant_q[idx] &&
          ((mask & ~out_ready) == '0) && ((mask & claimed) == '0)) begin
        grant_d[idx] = 1'b1;
        claimed      = claimed | mask;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (mask[j]) pend_sel_d[j*SEL_W +: SEL_W] = idx;
        end
        if (!found) begin
          found = 1'b1;
          rr_d  = idx + 1'b1;
        end
        if (mask == '0) drops = drops + 3'd1;
      end
    end
    pend_vld_d = claimed;

    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drops);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    out_sel_d = out_sel_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (pend_vld_q[j]) out_sel_d[j*SEL_W +: SEL_W] = pend_sel_q[j*SEL_W +: SEL_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_q        <= '0;
      pend_vld_q  <= '0;
      pend_sel_q  <= '0;
      out_valid_q <= '0;
      out_sel_q   <= '0;
      drop_q      <= '0;
    end else begin
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      pend_vld_q  <= pend_vld_d;
      pend_sel_q  <= pend_sel_d;
      out_valid_q <= pend_vld_q;
      out_sel_q   <= out_sel_d;
      drop_q      <= drop_d;
    end
  end

  assign grant      = grant_q;
  assign out_valid  = out_valid_q;
  assign out_sel    = out_sel_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: directed cycle table, saturation and reset sequences, then random traffic vs a reference model.
module tb_switch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_target;
  logic [3:0]  out_ready;
  logic [3:0]  grant;
  logic [3:0]  out_valid;
  logic [7:0]  out_sel;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_mis = 0;

  switch_arbiter #(.NUM_PORTS(4), .SEL_W(2), .DROP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_target (req_target),
    .out_ready  (out_ready),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] t;
    logic [3:0]  r;
    logic [3:0]  eg;
    logic [3:0]  eov;
    logic [7:0]  esel;
    logic [7:0]  edc;
  } vec_t;

  vec_t tbl[15];

  // Reference model state: what the outputs must show after the next edge.
  logic [3:0] m_grant, m_pv, m_ov;
  int         m_rr, m_dc;
  int         m_psrc[4];
  int         m_sel[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] t, input logic [3:0] r);
    req_valid  = v;
    req_target = t;
    out_ready  = r;
  endtask

  task automatic model_reset();
    m_grant = '0; m_pv = '0; m_ov = '0; m_rr = 0; m_dc = 0;
    for (int j = 0; j < 4; j++) begin
      m_psrc[j] = 0;
      m_sel[j]  = 0;
    end
  endtask

  // Walk the ports in priority order starting at the pointer; a port takes
  // its whole destination set only if it is ready and free of earlier claims.
  task automatic model_step(input logic [3:0] v, input logic [15:0] t, input logic [3:0] r);
    int         order[4];
    logic [3:0] taken, winners, want;
    int         src[4];
    int         first, ndrop;
    taken = '0; winners = '0; first = -1; ndrop = 0;
    for (int j = 0; j < 4; j++) src[j] = m_psrc[j];
    for (int k = 0; k < 4; k++) order[k] = (m_rr + k) % 4;
    foreach (order[k]) begin
      int p;
      p    = order[k];
      want = t[p*4 +: 4];
      if (!v[p] || m_grant[p]) continue;
      if ((want & r) != want) continue;
      if ((want & taken) != 0) continue;
      winners[p] = 1'b1;
      taken      = taken | want;
      for (int j = 0; j < 4; j++) if (want[j]) src[j] = p;
      if (first < 0) first = p;
      if (want == 0) ndrop++;
    end
    m_ov = m_pv;
    for (int j = 0; j < 4; j++) if (m_pv[j]) m_sel[j] = m_psrc[j];
    m_pv    = taken;
    m_psrc  = src;
    m_grant = winners;
    m_dc    = (m_dc + ndrop > 255) ? 255 : m_dc + ndrop;
    if (first >= 0) m_rr = (first + 1) % 4;
  endtask

  function automatic logic [15:0] rand_targets();
    logic [15:0] t;
    for (int p = 0; p < 4; p++) begin
      int c;
      c = $urandom_range(0, 99);
      if (c < 10)      t[p*4 +: 4] = 4'b0000;
      else if (c < 45) t[p*4 +: 4] = 4'(1 << $urandom_range(0, 3));
      else if (c < 55) t[p*4 +: 4] = 4'b1111;
      else             t[p*4 +: 4] = 4'($urandom);
    end
    return t;
  endfunction

  initial begin
    logic [7:0] msel;
    logic [3:0] rv, rr;
    logic [15:0] rt;

    //        v        t          r        eg       eov      esel   edc
    tbl[0]  = '{4'b0100, 16'h0100, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'd0};
    tbl[1]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0100, 4'b0000, 8'h00, 8'd0};
    tbl[2]  = '{4'b1001, 16'h8001, 4'b1111, 4'b0000, 4'b0001, 8'h02, 8'd0};
    tbl[3]  = '{4'b0000, 16'h0000, 4'b1111, 4'b1001, 4'b0000, 8'h02, 8'd0};
    tbl[4]  = '{4'b0011, 16'h0022, 4'b1111, 4'b0000, 4'b1001, 8'hC0, 8'd0};
    tbl[5]  = '{4'b0011, 16'h0022, 4'b1111, 4'b0001, 4'b0000, 8'hC0, 8'd0};
    tbl[6]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0010, 4'b0010, 8'hC0, 8'd0};
    tbl[7]  = '{4'b0010, 16'h00F0, 4'b1110, 4'b0000, 4'b0010, 8'hC4, 8'd0};
    tbl[8]  = '{4'b0010, 16'h00F0, 4'b1111, 4'b0000, 4'b0000, 8'hC4, 8'd0};
    tbl[9]  = '{4'b0000, 16'h0000, 4'b1111, 4'b0010, 4'b0000, 8'hC4, 8'd0};
    tbl[10] = '{4'b0100, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 8'h55, 8'd0};
    tbl[11] = '{4'b0000, 16'h0000, 4'b1111, 4'b0100, 4'b0000, 8'h55, 8'd1};
    tbl[12] = '{4'b1000, 16'h4000, 4'b1111, 4'b0000, 4'b0000, 8'h55, 8'd1};
    tbl[13] = '{4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'b0000, 8'h55, 8'd1};
    tbl[14] = '{4'b0000, 16'h0000, 4'b1111, 4'b0000, 4'b0100, 8'h75, 8'd1};

    drive(4'b0, 16'h0, 4'b0);
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      check($sformatf("tbl%0d grant", k),      32'(grant),      32'(tbl[k].eg));
      check($sformatf("tbl%0d out_valid", k),  32'(out_valid),  32'(tbl[k].eov));
      check($sformatf("tbl%0d out_sel", k),    32'(out_sel),    32'(tbl[k].esel));
      check($sformatf("tbl%0d drop_count", k), 32'(drop_count), 32'(tbl[k].edc));
      drive(tbl[k].v, tbl[k].t, tbl[k].r);
      tick();
    end

    // Port 2 drops continuously; it can win only every other cycle.
    drive(4'b0100, 16'h0000, 4'b1111);
    for (int i = 0; i < 19; i++) tick();
    check("drop_count after 20 edges", 32'(drop_count), 32'd11);
    for (int i = 0; i < 580; i++) tick();
    check("drop_count saturated", 32'(drop_count), 32'd255);
    tick();
    check("drop_count holds", 32'(drop_count), 32'd255);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst grant",      32'(grant),      32'd0);
    check("async rst out_valid",  32'(out_valid),  32'd0);
    check("async rst out_sel",    32'(out_sel),    32'd0);
    check("async rst drop_count", 32'(drop_count), 32'd0);
    drive(4'b1111, 16'h1111, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-rst grant 1", 32'(grant), 32'b0001);
    tick();
    check("post-rst grant 2", 32'(grant), 32'b0010);
    check("post-rst ov 2",    32'(out_valid), 32'b0001);
    check("post-rst sel 2",   32'(out_sel), 32'h00);
    tick();
    check("post-rst grant 3", 32'(grant), 32'b0100);
    check("post-rst sel 3",   32'(out_sel), 32'h01);

    drive(4'b0, 16'h0, 4'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      rv = 4'($urandom);
      rt = rand_targets();
      for (int j = 0; j < 4; j++) rr[j] = ($urandom_range(0, 99) < 85);
      drive(rv, rt, rr);
      model_step(rv, rt, rr);
      tick();
      for (int j = 0; j < 4; j++) msel[j*2 +: 2] = m_sel[j][1:0];
      check($sformatf("rnd%0d grant", i),      32'(grant),      32'(m_grant));
      check($sformatf("rnd%0d out_valid", i),  32'(out_valid),  32'(m_ov));
      check($sformatf("rnd%0d out_sel", i),    32'(out_sel),    32'(msel));
      check($sformatf("rnd%0d drop_count", i), 32'(drop_count), 32'(m_dc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Central arbiter that answers the per-port requests raised by the ingress `switch_port` instances of the 4-port switch. Each cycle it resolves contention for the four egress outputs, including multicast and broadcast masks. It issues a one-cycle `grant` pulse that pops the winning port's FIFO, then drives each output's `mux_select` and `valid` one cycle later, when the popped word is present. Zero-target requests are popped and counted as drops.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of ingress ports and egress outputs; only 4 is supported.
- `SEL_W`, 2, width of one output's mux select; must equal log2(`NUM_PORTS`).
- `DROP_W`, 8, width of the saturating drop counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_PORTS`  bit i: port i has a packet at its FIFO head.
- `req_target`  in  4*`NUM_PORTS`  bits [4i+3:4i]: port i target mask; bit j set means output j is a destination.
- `out_ready`  in  `NUM_PORTS`  bit j: egress j can accept a word.
- `grant`  out  `NUM_PORTS`  one-cycle pop pulse per port, registered.
- `out_valid`  out  `NUM_PORTS`  bit j: egress j carries a word this cycle.
- `out_sel`  out  `SEL_W`*`NUM_PORTS`  bits [2j+1:2j]: source port index for output j.
- `drop_count`  out  `DROP_W`  count of zero-mask packets dropped, saturating.

## Operation
- **Reset (async).** `grant`, `out_valid`, `out_sel`, `drop_count` and `rr_ptr` (2-bit round-robin pointer) all go to 0.
- **Eligibility in cycle C.** Port i is eligible when all three hold:
  - `req_valid[i]` = 1;
  - `grant[i]` = 0 in C, because its request is the stale head that is being popped;
  - every output j with mask bit j set has `out_ready[j]` = 1.
- **Search order.** Ports are scanned in order `rr_ptr`, `rr_ptr`+1, ... mod 4.
  - An eligible port wins if none of its mask bits overlaps outputs already claimed earlier in this scan.
  - A winner claims all outputs in its mask.
  - Several ports may win in one cycle if their masks are disjoint.
- **Multicast is all-or-nothing.** A port never receives a partial set of its outputs.
- **Zero mask (ERR or unroutable).** The port wins unconditionally, claims no output, and is popped. `drop_count` increments by 1, saturating at 2^`DROP_W`-1.
- **Pointer update.** `rr_ptr` becomes (index of the first winner in scan order + 1) mod 4. It is unchanged if there is no winner.
- **Fairness.** The port at `rr_ptr` always wins if eligible. A continuously eligible port is therefore granted within 4 winning cycles.
- **Hold behaviour.** `out_sel` of output j holds its last value when `out_valid[j]` = 0.

## Timing
- Requests sampled in cycle C produce `grant` in C+1 (registered).
- The FIFO pops at the end of C+1.
- `out_valid[j]` and `out_sel[j]` are asserted in C+2 for exactly one cycle, aligned with the FIFO read data.
- Throughput: one word per output per cycle, fully pipelined. The same output may be granted in consecutive cycles to different ports.
- A granted port cannot win in the following cycle. Its maximum rate is therefore one packet per 2 cycles.
- `out_ready` is sampled only in arbitration cycle C. Deassertion after C does not cancel the grant.
- Reset asserted mid-pipeline clears both pipeline stages immediately; in-flight grants are lost.
- `drop_count` updates in C+1, together with the drop's `grant`.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-traffic -> all outputs 0 asynchronously, `rr_ptr`=0. After release, the first grant follows scan order from port 0.
- **Unicast.** Port 2, mask 0001, `out_ready`=1111, in cycle C -> `grant`=0100 in C+1; `out_valid`=0001 and `out_sel[1:0]`=2 in C+2; `rr_ptr`=3.
- **Contention.** Ports 0 and 1 both target 0010, `rr_ptr`=0 -> `grant`=0001, then `grant`=0010 the next cycle. Port 0 is held off by the stale mask; `rr_ptr` ends at 2.
- **Disjoint parallel.** Port 0 mask 0001 and port 3 mask 1000 together -> `grant`=1001 in one cycle; `out_valid`=1001 with sel0=0 and sel3=3.
- **Broadcast stall.** Port 1 mask 1111 with `out_ready`=1110 -> no grant. Raise `out_ready[0]` -> `grant`=0010 next cycle, then `out_valid`=1111 with all sels=1.
- **Drop.** Port 2 mask 0000, valid -> `grant`=0100, `out_valid`=0000, `drop_count` 0->1. With 300 drops, `drop_count` holds at 255.
